// File: rtl/ntt_pkg.sv
// Shared types and helpers for the NTT datapath delay line.
package ntt_pkg;

   // Occupancy-derived control state of the delay line.
   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } delay_state_t;

   // A depth is usable when it selects at least one and at most max_d stages.
   function automatic logic is_legal_depth(input int d, input int max_d);
      return (d >= 1) && (d <= max_d);
   endfunction

endpackage

// File: rtl/ntt_delay_mem.sv
// Circular storage for the delay line: one write port, one asynchronous
// read port, per-entry valid bits and a single-cycle clear of all valid bits.
// Data bits are deliberately left unreset so the array maps to distributed RAM.
module ntt_delay_mem
   import ntt_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             wvalid,
   input  logic             clear_all,
   input  logic [AW-1:0]    raddr,
   output logic             rvalid,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem_array [DEPTH];
   logic [DEPTH-1:0] valid_reg;
   logic [DEPTH-1:0] valid_next;

   // Data array write; contents are qualified by the valid bits on read.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_array[waddr] <= wdata;
      end
   end

   // Valid bits: a clear wipes everything first, then a same-cycle write lands.
   always_comb begin
      valid_next = valid_reg;
      if (clear_all) begin
         valid_next = '0;
      end
      if (we) begin
         valid_next[waddr] = wvalid;
      end
   end

   // Valid-bit register; these must reset so stale data never looks live.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_reg <= '0;
      end else begin
         valid_reg <= valid_next;
      end
   end

   assign rvalid = valid_reg[raddr];
   assign rdata  = mem_array[raddr];

endmodule

// File: rtl/ntt_delay_line.sv
// Stallable, runtime-depth delay line carrying CH lanes plus a valid bit.
// With en held high and depth D it behaves like a D-stage register chain.
module ntt_delay_line
   import ntt_pkg::*;
#(
   parameter int DATA      = 32,
   parameter int CH        = 1,
   parameter int MAX_DEPTH = 16,
   parameter int DW        = $clog2(MAX_DEPTH + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   input  logic               in_valid,
   input  logic [CH*DATA-1:0] in_data,
   output logic               out_valid,
   output logic [CH*DATA-1:0] out_data,
   input  logic               flush,
   input  logic               cfg_valid,
   input  logic [DW-1:0]      cfg_depth,
   output logic               cfg_ready,
   output logic               cfg_err,
   output logic [DW-1:0]      depth,
   output logic [DW-1:0]      occupancy
);

   localparam int AW = $clog2(MAX_DEPTH);
   localparam int W  = CH * DATA;
   localparam int SW = DW + 1;

   delay_state_t  state_reg, state_next;
   logic [AW-1:0] wptr_reg, wptr_next;
   logic [DW-1:0] depth_reg, depth_next;
   logic [DW-1:0] occ_reg, occ_next;
   logic [DW-1:0] occ_base;
   logic          cfg_err_reg, cfg_err_next;
   logic          cfg_accept;
   logic          mem_clear;
   logic          advance;
   logic [SW-1:0] rd_sum;
   logic [AW-1:0] rd_addr;
   logic          rd_valid;
   logic [W-1:0]  rd_data;

   assign advance = en && !flush;

   ntt_delay_mem #(
      .WIDTH (W),
      .DEPTH (MAX_DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk       (clk),
      .reset     (reset),
      .we        (advance),
      .waddr     (wptr_reg),
      .wdata     (in_data),
      .wvalid    (in_valid),
      .clear_all (mem_clear),
      .raddr     (rd_addr),
      .rvalid    (rd_valid),
      .rdata     (rd_data)
   );

   // Output entry is (wptr - D) mod MAX_DEPTH, computed without negatives.
   always_comb begin
      rd_sum = SW'(wptr_reg) + SW'(MAX_DEPTH) - SW'(depth_reg);
      if (rd_sum >= SW'(MAX_DEPTH)) begin
         rd_sum = rd_sum - SW'(MAX_DEPTH);
      end
      rd_addr = AW'(rd_sum);
   end

   // Next-state logic: cfg handshake, flush, advance and occupancy tracking.
   always_comb begin
      state_next   = state_reg;
      wptr_next    = wptr_reg;
      depth_next   = depth_reg;
      occ_next     = occ_reg;
      cfg_err_next = 1'b0;
      mem_clear    = 1'b0;
      cfg_accept   = cfg_valid && (state_reg == IDLE);
      occ_base     = cfg_accept ? '0 : occ_reg;

      // Depth changes are only taken while empty; the clear drops stale entries.
      if (cfg_accept) begin
         mem_clear = 1'b1;
         if (is_legal_depth(int'(cfg_depth), MAX_DEPTH)) begin
            depth_next = cfg_depth;
         end else begin
            cfg_err_next = 1'b1;
         end
      end

      if (flush) begin
         mem_clear  = 1'b1;
         occ_next   = '0;
         state_next = IDLE;
      end else if (en) begin
         wptr_next  = (wptr_reg == AW'(MAX_DEPTH - 1)) ? '0 : wptr_reg + AW'(1);
         occ_next   = occ_base + DW'(in_valid) - DW'(rd_valid && !cfg_accept);
         state_next = (occ_next != '0) ? RUN : IDLE;
      end
   end

   // State registers with asynchronous reset to the empty, full-depth line.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg   <= IDLE;
         wptr_reg    <= '0;
         depth_reg   <= DW'(MAX_DEPTH);
         occ_reg     <= '0;
         cfg_err_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         wptr_reg    <= wptr_next;
         depth_reg   <= depth_next;
         occ_reg     <= occ_next;
         cfg_err_reg <= cfg_err_next;
      end
   end

   assign out_valid = rd_valid;
   assign out_data  = rd_valid ? rd_data : '0;
   assign cfg_ready = cfg_accept;
   assign cfg_err   = cfg_err_reg;
   assign depth     = depth_reg;
   assign occupancy = occ_reg;

endmodule

// File: tb/tb_ntt_delay_line.sv
// Directed bench for ntt_delay_line: reset, depth change, stalls, handshake,
// wrap/stale handling, flush and asynchronous reset.
module tb_ntt_delay_line;

   localparam int DATA = 32;
   localparam int CH   = 1;
   localparam int MAXD = 16;
   localparam int DW   = $clog2(MAXD + 1);

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               en = 1'b0;
   logic               in_valid = 1'b0;
   logic [CH*DATA-1:0] in_data = '0;
   logic               flush = 1'b0;
   logic               cfg_valid = 1'b0;
   logic [DW-1:0]      cfg_depth = '0;
   logic               out_valid;
   logic [CH*DATA-1:0] out_data;
   logic               cfg_ready;
   logic               cfg_err;
   logic [DW-1:0]      depth;
   logic [DW-1:0]      occupancy;

   int n_checks = 0;
   int n_fail   = 0;

   ntt_delay_line #(
      .DATA      (DATA),
      .CH        (CH),
      .MAX_DEPTH (MAXD),
      .DW        (DW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_data  (out_data),
      .flush     (flush),
      .cfg_valid (cfg_valid),
      .cfg_depth (cfg_depth),
      .cfg_ready (cfg_ready),
      .cfg_err   (cfg_err),
      .depth     (depth),
      .occupancy (occupancy)
   );

   always #5 clk = ~clk;

   // One clock edge, then settle 1 time unit before sampling or driving.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      n_checks++;
      if ({out_valid, out_data} !== '0) begin
         n_fail++;
         $display("FAIL reset_out: got %h required 0", {out_valid, out_data});
      end
      n_checks++;
      if (depth !== DW'(MAXD)) begin
         n_fail++;
         $display("FAIL reset_depth: got %0d required %0d", depth, MAXD);
      end
      n_checks++;
      if ({occupancy, cfg_ready, cfg_err} !== '0) begin
         n_fail++;
         $display("FAIL reset_ctrl: occ=%0d ready=%b err=%b required 0/0/0", occupancy, cfg_ready, cfg_err);
      end
      reset = 1'b0;
      #1;
      $display("test_reset: done");
   endtask

   task automatic test_defaults();
      logic [DATA:0] exp;
      en = 1'b1; in_valid = 1'b1; in_data = 32'hA5;
      step();
      in_valid = 1'b0; in_data = '0;
      n_checks++;
      if (occupancy !== DW'(1)) begin
         n_fail++;
         $display("FAIL default_occ: got %0d required 1", occupancy);
      end
      for (int k = 1; k <= 17; k++) begin
         if (k > 1) step();
         exp = (k == 16) ? {1'b1, 32'hA5} : '0;
         n_checks++;
         if ({out_valid, out_data} !== exp) begin
            n_fail++;
            $display("FAIL default_out[%0d]: got %h required %h", k, {out_valid, out_data}, exp);
         end
      end
      n_checks++;
      if (occupancy !== '0) begin
         n_fail++;
         $display("FAIL default_drain_occ: got %0d required 0", occupancy);
      end
      $display("test_defaults: word 0xA5 tracked through depth 16");
   endtask

   task automatic test_reconfig_stall();
      logic [DATA:0] exp;
      en = 1'b0; cfg_valid = 1'b1; cfg_depth = DW'(3);
      #1;
      n_checks++;
      if (cfg_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL cfg3_ready: got %b required 1", cfg_ready);
      end
      step();
      cfg_valid = 1'b0;
      #1;
      n_checks++;
      if ({depth, cfg_err} !== {DW'(3), 1'b0}) begin
         n_fail++;
         $display("FAIL cfg3_depth: depth=%0d err=%b required 3/0", depth, cfg_err);
      end
      en = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         in_valid = 1'b1; in_data = 32'(k);
         step();
         exp = (k >= 3) ? {1'b1, 32'(k - 2)} : '0;
         n_checks++;
         if ({out_valid, out_data} !== exp) begin
            n_fail++;
            $display("FAIL stream3_out[%0d]: got %h required %h", k, {out_valid, out_data}, exp);
         end
      end
      n_checks++;
      if (occupancy !== DW'(3)) begin
         n_fail++;
         $display("FAIL stream3_occ: got %0d required 3", occupancy);
      end
      // Stall: input is ignored, output and occupancy hold.
      en = 1'b0; in_data = 32'd99;
      for (int k = 0; k < 2; k++) begin
         step();
         n_checks++;
         if ({out_valid, out_data, occupancy} !== {1'b1, 32'd4, DW'(3)}) begin
            n_fail++;
            $display("FAIL stall_hold[%0d]: got v=%b d=%0d occ=%0d required 1/4/3", k, out_valid, out_data, occupancy);
         end
      end
      en = 1'b1; in_data = 32'd7;
      step();
      n_checks++;
      if ({out_valid, out_data} !== {1'b1, 32'd5}) begin
         n_fail++;
         $display("FAIL stall_resume: got %h required 5 valid", {out_valid, out_data});
      end
      in_valid = 1'b0; in_data = '0;
      for (int k = 0; k < 3; k++) begin
         step();
         exp = (k < 2) ? {1'b1, 32'(6 + k)} : '0;
         n_checks++;
         if ({out_valid, out_data, occupancy} !== {exp, DW'(2 - k)}) begin
            n_fail++;
            $display("FAIL drain3[%0d]: got v=%b d=%0d occ=%0d required %h occ %0d", k, out_valid, out_data, occupancy, exp, 2 - k);
         end
      end
      $display("test_reconfig_stall: depth 3 stream with 2-cycle stall");
   endtask

   task automatic test_handshake();
      logic [DW-1:0] bad [2];
      bad[0] = DW'(0);
      bad[1] = DW'(MAXD + 1);
      en = 1'b1; in_valid = 1'b1; in_data = 32'h11;
      step();
      in_valid = 1'b0; in_data = '0;
      cfg_valid = 1'b1; cfg_depth = DW'(5);
      #1;
      n_checks++;
      if (cfg_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL hs_run_ready: got %b required 0", cfg_ready);
      end
      for (int k = 2; k <= 4; k++) begin
         step();
         n_checks++;
         if (cfg_ready !== (k == 4)) begin
            n_fail++;
            $display("FAIL hs_ready[%0d]: got %b required %b", k, cfg_ready, (k == 4));
         end
         if (k == 3) begin
            n_checks++;
            if ({out_valid, out_data} !== {1'b1, 32'h11}) begin
               n_fail++;
               $display("FAIL hs_word: got %h required 0x11 valid", {out_valid, out_data});
            end
         end
      end
      step();
      cfg_valid = 1'b0;
      #1;
      n_checks++;
      if ({depth, cfg_err} !== {DW'(5), 1'b0}) begin
         n_fail++;
         $display("FAIL hs_accept: depth=%0d err=%b required 5/0", depth, cfg_err);
      end
      for (int i = 0; i < 2; i++) begin
         cfg_valid = 1'b1; cfg_depth = bad[i];
         #1;
         n_checks++;
         if (cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bad_ready[%0d]: got %b required 1", bad[i], cfg_ready);
         end
         step();
         cfg_valid = 1'b0;
         n_checks++;
         if ({cfg_err, depth} !== {1'b1, DW'(5)}) begin
            n_fail++;
            $display("FAIL bad_err[%0d]: err=%b depth=%0d required 1/5", bad[i], cfg_err, depth);
         end
         step();
         n_checks++;
         if (cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_err_pulse[%0d]: got %b required 0", bad[i], cfg_err);
         end
      end
      // Accept and advance in the same cycle: the word uses the new depth.
      cfg_valid = 1'b1; cfg_depth = DW'(2); in_valid = 1'b1; in_data = 32'h22;
      step();
      cfg_valid = 1'b0; in_valid = 1'b0; in_data = '0;
      #1;
      n_checks++;
      if ({depth, occupancy, out_valid} !== {DW'(2), DW'(1), 1'b0}) begin
         n_fail++;
         $display("FAIL simul_cfg: depth=%0d occ=%0d v=%b required 2/1/0", depth, occupancy, out_valid);
      end
      step();
      n_checks++;
      if ({out_valid, out_data} !== {1'b1, 32'h22}) begin
         n_fail++;
         $display("FAIL simul_word: got %h required 0x22 valid", {out_valid, out_data});
      end
      step();
      n_checks++;
      if ({out_valid, occupancy} !== {1'b0, DW'(0)}) begin
         n_fail++;
         $display("FAIL simul_drain: v=%b occ=%0d required 0/0", out_valid, occupancy);
      end
      $display("test_handshake: hold-off, illegal depths 0 and %0d, same-cycle accept", MAXD + 1);
   endtask

   task automatic test_wrap_stale();
      logic [DATA:0] exp;
      en = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         in_valid = 1'b1; in_data = 32'(100 + k);
         step();
         exp = (k >= 2) ? {1'b1, 32'(100 + k - 1)} : '0;
         n_checks++;
         if ({out_valid, out_data} !== exp) begin
            n_fail++;
            $display("FAIL wrap_out[%0d]: got %h required %h", k, {out_valid, out_data}, exp);
         end
      end
      in_valid = 1'b0; in_data = '0;
      step();
      n_checks++;
      if ({out_valid, out_data} !== {1'b1, 32'd140}) begin
         n_fail++;
         $display("FAIL wrap_last: got %h required 140 valid", {out_valid, out_data});
      end
      step();
      n_checks++;
      if ({out_valid, occupancy} !== {1'b0, DW'(0)}) begin
         n_fail++;
         $display("FAIL wrap_drain: v=%b occ=%0d required 0/0", out_valid, occupancy);
      end
      en = 1'b0; cfg_valid = 1'b1; cfg_depth = DW'(MAXD);
      step();
      cfg_valid = 1'b0;
      #1;
      n_checks++;
      if ({depth, out_valid} !== {DW'(MAXD), 1'b0}) begin
         n_fail++;
         $display("FAIL stale_cfg: depth=%0d v=%b required %0d/0", depth, out_valid, MAXD);
      end
      en = 1'b1; in_valid = 1'b1; in_data = 32'h5A;
      step();
      in_valid = 1'b0; in_data = '0;
      for (int k = 1; k <= MAXD; k++) begin
         if (k > 1) step();
         exp = (k == MAXD) ? {1'b1, 32'h5A} : '0;
         n_checks++;
         if ({out_valid, out_data} !== exp) begin
            n_fail++;
            $display("FAIL stale_out[%0d]: got %h required %h", k, {out_valid, out_data}, exp);
         end
      end
      step();
      $display("test_wrap_stale: 40 words at depth 2, then single word at depth %0d", MAXD);
   endtask

   task automatic test_flush_reset();
      en = 1'b0; cfg_valid = 1'b1; cfg_depth = DW'(8);
      step();
      cfg_valid = 1'b0;
      en = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         in_valid = 1'b1; in_data = 32'(200 + k);
         step();
      end
      n_checks++;
      if ({out_valid, out_data, occupancy} !== {1'b1, 32'd203, DW'(8)}) begin
         n_fail++;
         $display("FAIL pre_flush: v=%b d=%0d occ=%0d required 1/203/8", out_valid, out_data, occupancy);
      end
      flush = 1'b1; in_data = 32'd77;
      step();
      flush = 1'b0; in_valid = 1'b0; in_data = '0;
      n_checks++;
      if ({out_valid, occupancy} !== {1'b0, DW'(0)}) begin
         n_fail++;
         $display("FAIL flush: v=%b occ=%0d required 0/0", out_valid, occupancy);
      end
      for (int k = 1; k <= 8; k++) begin
         step();
         n_checks++;
         if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL post_flush[%0d]: out_valid got %b required 0", k, out_valid);
         end
      end
      for (int k = 1; k <= 5; k++) begin
         in_valid = 1'b1; in_data = 32'(300 + k);
         step();
      end
      in_valid = 1'b0; in_data = '0;
      n_checks++;
      if (occupancy !== DW'(5)) begin
         n_fail++;
         $display("FAIL pre_reset_occ: got %0d required 5", occupancy);
      end
      // Asynchronous reset between clock edges.
      reset = 1'b1;
      #1;
      n_checks++;
      if ({out_valid, out_data, occupancy, cfg_err, depth} !== {1'b0, 32'd0, DW'(0), 1'b0, DW'(MAXD)}) begin
         n_fail++;
         $display("FAIL async_reset: v=%b d=%h occ=%0d err=%b depth=%0d required 0/0/0/0/%0d", out_valid, out_data, occupancy, cfg_err, depth, MAXD);
      end
      reset = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         step();
         n_checks++;
         if ({out_valid, out_data} !== '0) begin
            n_fail++;
            $display("FAIL post_reset[%0d]: got %h required 0", k, {out_valid, out_data});
         end
      end
      $display("test_flush_reset: flush at depth 8 and mid-stream reset");
   endtask

   initial begin
      test_reset();
      test_defaults();
      test_reconfig_stall();
      test_handshake();
      test_wrap_stale();
      test_flush_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ntt_delay_line.md
# ntt_delay_line

Parametrised, stallable delay line for the NTT datapath. It carries CH lanes of DATA-bit words plus a per-word valid bit through a runtime-selectable depth of 1..MAX_DEPTH advance steps. Butterfly units and address generators use it to align operands whose latency depends on the NTT stage or ring size, instead of relying on fixed-depth registers. With `en` held high and depth D it is cycle-equivalent to a D-stage register chain.

## Interface
- `DATA`, default 32: word width per lane
- `CH`, default 1: lane count; all lanes share depth, valid and enable
- `MAX_DEPTH`, default 16: maximum delay in advance steps, ≥2
- `DW`, default `$clog2(MAX_DEPTH+1)`: width of depth and occupancy fields
- `clk`: input, 1 bit. Clock.
- `reset`: input, 1 bit. Reset; asynchronous, active-high.
- `en`: input, 1 bit. Advance strobe; 0 freezes all storage and outputs.
- `in_valid`: input, 1 bit. The word on `in_data` is meaningful.
- `in_data`: input, CH*DATA bits. Input lanes; lane k occupies bits [k*DATA +: DATA].
- `out_valid`: output, 1 bit. Valid bit of the word leaving the line.
- `out_data`: output, CH*DATA bits. Output lanes; all-zero whenever `out_valid`=0.
- `flush`: input, 1 bit. Synchronous invalidate of all stored words.
- `cfg_valid`: input, 1 bit. Depth-change request.
- `cfg_depth`: input, DW bits. Requested depth.
- `cfg_ready`: output, 1 bit. Depth change accepted this cycle.
- `cfg_err`: output, 1 bit. One-cycle pulse: the accepted request had an illegal depth.
- `depth`: output, DW bits. Current depth D.
- `occupancy`: output, DW bits. Count of valid words currently inside the window.

## Operation
- Storage is a circular buffer of MAX_DEPTH entries. Each entry holds CH*DATA data bits and 1 valid bit. Write pointer `wptr` is mod MAX_DEPTH.
- Advance is a cycle with `en`=1 and `flush`=0. On each advance:
  - write {`in_valid`, `in_data`} at `wptr`;
  - `wptr`++ with wrap from MAX_DEPTH-1 to 0;
  - occupancy += `in_valid` − `out_valid`.
- Output entry index is (`wptr` − D) mod MAX_DEPTH. `out_valid` and `out_data` are combinational from that entry; `out_data` is masked to 0 when the entry is invalid.
- A word written on advance n is presented on the output after exactly D further advances. Non-advance cycles do not count.
- States:
  - IDLE: occupancy=0.
  - RUN: occupancy>0.
  - IDLE→RUN on an advance with `in_valid`=1.
  - RUN→IDLE when occupancy reaches 0, on flush, or on reset.
- `cfg_ready` = `cfg_valid` && (state==IDLE).
  - A request in RUN is held off; the requester keeps `cfg_valid` asserted.
- On an accepted request with 1 ≤ `cfg_depth` ≤ MAX_DEPTH:
  - D ← `cfg_depth`;
  - all valid bits are cleared, which discards stale entries outside the old window;
  - `wptr` is kept.
- On an accepted request with `cfg_depth`=0 or `cfg_depth`>MAX_DEPTH: `cfg_err` pulses for the next cycle and D is unchanged. The valid-bit clear still happens.
- Flush: all valid bits are cleared, occupancy←0, and the same-cycle input is discarded. Flush has priority over `en`.
- Simultaneous cfg accept and advance in IDLE: the input word is written after the clear and travels with the new D.
- Reset values: D=MAX_DEPTH, `wptr`=0, all valid bits 0, occupancy=0, `out_valid`=0, `out_data`=0, `cfg_ready`=0, `cfg_err`=0.
- Data bits of entries are not reset; this is allowed because `out_data` is masked by the valid bit.
- Reset asserted mid-stream discards all in-flight words. There is no partial output after release.

## Timing
- Latency is D advancing clock edges from input sample to output. With `en`=1 continuously this is D cycles, and throughput is 1 word/cycle.
- `out_*`, `depth` and `occupancy` update only on clock edges, from registered state.
- `cfg_ready` is combinational from `cfg_valid` and state.
- `cfg_err` is registered and asserted for one cycle.
- The new depth takes effect on the edge that accepts the request. The first output under the new depth is D advances after the next valid write.
- occupancy never exceeds D. This is guaranteed because a word leaves in the same advance that a word enters once the window is full.

## Structure
- Shared package `ntt_pkg`:
  - `delay_state_t` enum {IDLE, RUN};
  - a depth-legality helper function.
- One sub-module, `ntt_delay_mem`: the MAX_DEPTH-entry array with one write port and one asynchronous read port, plus per-entry valid bits and a clear-all input.
  - The array is separated so that it maps to distributed RAM.
  - Pointer, occupancy and cfg logic stay in the top module.

## Test plan
- **Reset defaults:** reset, then `en`=1, one valid word 0xA5 at cycle 0 → `out_valid`=1 with 0xA5 exactly at cycle 16; `depth`=16.
- **Reconfigure and stall:** cfg D=3, stream 1,2,3,… with `en`=1 → outputs 1,2,3 from cycle 3. Drop `en` for 2 cycles → output frozen, and the next value appears 1 advance later.
- **Handshake:** cfg request in RUN → `cfg_ready`=0 until the last word exits, then accepted. Request `cfg_depth`=0 → `cfg_err` pulses once and `depth` is unchanged.
- **Stale entries and pointer wrap:** D=2, run 40 words so `wptr` wraps, drain, reconfigure to D=MAX_DEPTH, stream one word → no stale word appears, and the single word arrives after exactly MAX_DEPTH advances.
- **Flush and reset priority:** flush with `en`=1 and `in_valid`=1 mid-stream → occupancy=0 next cycle and no output for the next D advances. Assert reset while occupancy=5 → all outputs 0 immediately, and nothing emerges after release.
